// File: rtl/mdu_seq_if.sv
// Handshake and register-file bundle between execute-stage control and the
// iterative multiply/divide unit.
interface mdu_seq_if #(
    parameter int DATA_SIZE = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] b;
    logic                 wr_hi;
    logic                 wr_lo;
    logic [DATA_SIZE-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic                 dbz;
    logic [DATA_SIZE-1:0] hi;
    logic [DATA_SIZE-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the HI/LO register pair:
// radix-2 shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mdu_seq #(
    parameter int DATA_SIZE = 32
) (
    input logic       clk,
    input logic       rst_n,
    mdu_seq_if.slave  bus
);
    localparam int N  = DATA_SIZE;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_res;   // product / quotient negation
    logic            neg_a;     // remainder takes the dividend's sign
    logic            b_zero;
    logic [N-1:0]    opm;       // multiplicand or divisor magnitude
    logic [2*N-1:0]  acc;       // {product} or {remainder, quotient}
    logic            busy_q, done_q, dbz_q;
    logic [N-1:0]    hi_q, lo_q;

    logic            a_sgn, b_sgn;
    logic [N-1:0]    a_mag, b_mag;
    logic [N:0]      mul_sum;
    logic [N:0]      div_shift;
    logic [N:0]      div_diff;
    logic            div_ok;
    logic [2*N-1:0]  acc_next;
    logic [2*N-1:0]  prod_neg;
    logic [N-1:0]    fix_hi, fix_lo;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        a_sgn     = ~bus.op[0] & bus.a[N-1];
        b_sgn     = ~bus.op[0] & bus.b[N-1];
        a_mag     = a_sgn ? (~bus.a + 1'b1) : bus.a;
        b_mag     = b_sgn ? (~bus.b + 1'b1) : bus.b;

        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opm} : '0);
        div_shift = {acc[2*N-1:N], acc[N-1]};
        div_ok    = (div_shift >= {1'b0, opm});
        div_diff  = div_shift - {1'b0, opm};

        acc_next  = {mul_sum, acc[N-1:1]};
        if (is_div)
            acc_next = {(div_ok ? div_diff[N-1:0] : div_shift[N-1:0]),
                        acc[N-2:0], div_ok};

        prod_neg  = ~acc + 1'b1;
        fix_hi    = neg_res ? prod_neg[2*N-1:N] : acc[2*N-1:N];
        fix_lo    = neg_res ? prod_neg[N-1:0]   : acc[N-1:0];
        if (is_div) begin
            // A zero divisor leaves the dividend magnitude in the remainder,
            // so the normal sign fix-up already restores hi = a.
            fix_hi = neg_a ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];
            if (b_zero)
                fix_lo = '1;
            else
                fix_lo = neg_res ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_a   <= 1'b0;
            b_zero  <= 1'b0;
            opm     <= '0;
            acc     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div  <= bus.op[1];
                        neg_res <= a_sgn ^ b_sgn;
                        neg_a   <= a_sgn;
                        b_zero  <= (bus.b == '0);
                        opm     <= bus.op[1] ? b_mag : a_mag;
                        acc     <= {{N{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        cnt     <= CW'(N - 1);
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        state   <= RUN;
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wdata;
                        if (bus.wr_lo) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    dbz_q  <= is_div & b_zero;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: expected results are queued at launch and
// compared when done pulses; latency, flags and HI/LO writes are also checked.
module tb_mdu_seq;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if #(.DATA_SIZE(N)) bus ();
    mdu_seq #(.DATA_SIZE(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string        tag;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input string tag, input logic [1:0] op,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t        e;
        longint      sa, sb_v, q, r;
        logic [63:0] p;
        sa   = $signed(a);
        sb_v = $signed(b);
        e.tag = tag;
        e.dbz = 1'b0;
        case (op)
            2'd0: begin p = sa * sb_v; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else if (op == 2'd2) begin
                    q = sa / sb_v; r = sa % sb_v;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic launch(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] ehi,
                          input logic [N-1:0] elo, input logic edbz);
        exp_t e;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_done0"}, 64'(bus.done), 64'd0);
        check({tag, "_dbzclr"}, 64'(bus.dbz), 64'd0);
    endtask

    task automatic launch_model(input string tag, input logic [1:0] op,
                                input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e = model(tag, op, a, b);
        launch(tag, op, a, b, e.hi, e.lo, e.dbz);
    endtask

    // from: edges already elapsed since the accepting edge; b2b leaves the
    // done cycle free for an immediate next launch.
    task automatic wait_done(input int from, input bit b2b);
        int   k;
        exp_t e;
        k = from;
        while (k < N + 8) begin
            @(posedge clk); #1;
            k++;
            if (bus.done) break;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 64'(bus.done), 64'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_latency"}, 64'(k), 64'(N + 1));
            if (bus.done) begin
                check({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
                check({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
                check({e.tag, "_dbz"}, 64'(bus.dbz), 64'(e.dbz));
                check({e.tag, "_busy0"}, 64'(bus.busy), 64'd0);
                if (!b2b) begin
                    @(posedge clk); #1;
                    check({e.tag, "_pulse"}, 64'(bus.done), 64'd0);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz",  64'(bus.dbz),  64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        @(negedge clk) rst_n = 1'b1;

        launch("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done(0, 1'b0);
        launch("mult_neg", 2'd0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        wait_done(0, 1'b0);
        launch("multu_neg", 2'd1, 32'hFFFF_FFF9, 32'd6, 32'h0000_0005, 32'hFFFF_FFD6, 1'b0);
        wait_done(0, 1'b0);
        launch("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(0, 1'b0);
        launch("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done(0, 1'b1);
        launch("divu_dbz", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        wait_done(0, 1'b1);

        // Back-to-back start in the done cycle also clears dbz; a second start
        // and an MTHI mid-run must both be ignored.
        launch("multu_mid", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd77; bus.b = 32'd7;
        bus.wr_hi = 1'b1; bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        check("busy_wr_hi", 64'(bus.hi), 64'd100);
        check("busy_hold", 64'(bus.busy), 64'd1);
        wait_done(6, 1'b0);

        @(negedge clk);
        bus.wr_lo = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        #1 check("wr_lo_pre", 64'(bus.lo), 64'd15);
        @(posedge clk); #1;
        bus.wr_lo = 1'b0;
        check("wr_lo", 64'(bus.lo), 64'hA5A5_A5A5);

        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0000_005A;
        @(posedge clk); #1;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("wr_both_hi", 64'(bus.hi), 64'h5A);
        check("wr_both_lo", 64'(bus.lo), 64'h5A);

        bus.wr_lo = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        launch("start_wins", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        bus.wr_lo = 1'b0;
        check("start_wins_lo", 64'(bus.lo), 64'h5A);
        wait_done(0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   op;
            logic [N-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            launch_model($sformatf("rnd%0d_op%0d", i, op), op, a, b);
            wait_done(0, (i % 2) == 1);
        end

        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        launch_model("abort", 2'd1, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi",   64'(bus.hi),   64'd0);
        check("abort_lo",   64'(bus.lo),   64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;

        launch("post_rst", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        wait_done(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, plus the HI/LO register pair.
- The combinational ALU does not implement these operations. This block sits beside it in the execute stage.
- Control issues a single-cycle start with operands. The block runs a radix-2 shift-add or restoring-divide loop, writes HI/LO, and pulses done.
- The pipeline stalls on busy. MFHI/MFLO read hi/lo directly; MTHI/MTLO write through the wr ports.

Parameters:
DATA_SIZE, 32, operand and HI/LO width (must be >= 2, even)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  DATA_SIZE  rs operand (multiplicand / dividend)
b  input  DATA_SIZE  rt operand (multiplier / divisor)
wr_hi  input  1  MTHI write strobe
wr_lo  input  1  MTLO write strobe
wdata  input  DATA_SIZE  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo hold the new result
dbz  output  1  divide-by-zero flag, valid with done, held until next start
hi  output  DATA_SIZE  HI register
lo  output  DATA_SIZE  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; iteration counter=0. Reset mid-operation aborts immediately; the partial result is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 latches op, operand magnitudes and operand signs (signed ops only).
  - Loads counter = DATA_SIZE-1, sets busy=1, clears dbz, then moves to RUN.
- RUN:
  - One iteration per clock.
  - Multiply: shift-add on a 2*DATA_SIZE accumulator.
  - Divide: restoring shift-subtract on a remainder/quotient pair.
  - Leaves for FIX when counter=0; counter decrements every cycle.
- FIX:
  - Applies sign correction.
  - Signed product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of a; quotient truncates toward zero.
  - Writes hi/lo, sets done=1 and busy=0, then returns to IDLE. done clears on the next edge.
- Latency: start sampled at edge E; done=1 and the new hi/lo are visible after edge E+DATA_SIZE+1. busy=1 after edges E..E+DATA_SIZE. Back-to-back: start may be asserted in the done cycle.
- Multiply result: hi = upper DATA_SIZE bits, lo = lower DATA_SIZE bits of the full 2*DATA_SIZE product.
- Divide result: lo = quotient, hi = remainder.
- Divide by zero (b=0):
  - Runs the full latency.
  - Result: lo = all ones, hi = a unmodified; dbz=1 with done.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0; dbz=0.
- start while busy: ignored; no queueing.
- op is don't-care when start=0.
- wr_hi/wr_lo:
  - In IDLE with start=0: the register takes wdata at the edge. Both may write in the same cycle.
  - Ignored while busy, in FIX, or when start=1 in the same cycle (start wins).
- hi/lo change only on reset, on the FIX write, or on an accepted wr_hi/wr_lo.

Test Plan:
- Reset → hi=lo=0, busy=done=dbz=0. Then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 edges done=1 for exactly one cycle, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9) b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6. Same operands with MULTU → hi=0x00000005, lo=0xFFFFFFD6.
- DIV a=-7 b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0.
- DIVU a=100 b=0 → done after 33 edges, lo=0xFFFFFFFF, hi=100, dbz=1. Next start clears dbz after the accepting edge.
- Second start pulsed mid-RUN with different operands → ignored; first result is delivered with unchanged latency. wr_hi=1 with wdata=0x1234 while busy → hi unaffected.
- wr_lo with wdata=0xA5A5A5A5 in IDLE → lo updates next edge. Drop rst_n mid-RUN → busy, done, hi and lo go to 0 immediately (async). After release, a new MULTU 3×4 gives lo=12, hi=0.
